// File: rtl/alarm_clock_pkg.sv
// Shared types and helpers for the alarm clock keypad control slice.
//   state_t       : control FSM states
//   KEY_ALARM/TIME: function key codes from the keypad scanner
//   bcd_time_t    : HH:MM as four BCD nibbles
//   time_is_valid : HH:MM range check (00:00 .. 23:59)
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_SHOW_ALARM
    } state_t;

    localparam logic [3:0] KEY_ALARM = 4'hA;
    localparam logic [3:0] KEY_TIME  = 4'hB;

    typedef struct packed {
        logic [3:0] ms_hr;
        logic [3:0] ls_hr;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
    } bcd_time_t;

    function automatic logic time_is_valid(input bcd_time_t t);
        logic ok;
        ok = (t.ms_hr <= 4'd2) && (t.ls_hr <= 4'd9) &&
             (t.ms_min <= 4'd5) && (t.ls_min <= 4'd9);
        // 20-23 are the only legal hours with a tens digit of 2
        if (t.ms_hr == 4'd2 && t.ls_hr > 4'd3)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/alarm_clock_ctrl_key_entry_buffer.sv
// key_entry_buffer: four-nibble shift register collecting keypad digits.
//   clk, reset    : clock, async active-high reset
//   clear         : zero buffer and count (with shift: start a fresh entry)
//   clear_count   : zero entry_count only, buffer keeps its value
//   shift, digit  : shift digit into the least-significant nibble
//   time_buf      : registered buffer contents
//   entry_count   : digits entered, saturating at 4
//   valid_time    : combinational, four digits present and in HH:MM range
module key_entry_buffer
    import alarm_clock_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       clear_count,
    input  logic       shift,
    input  logic [3:0] digit,
    output bcd_time_t  time_buf,
    output logic [2:0] entry_count,
    output logic       valid_time
);

    bcd_time_t base;

    // Shifting with clear asserted shifts into an all-zero buffer
    always_comb begin
        base = clear ? '0 : time_buf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_buf    <= '0;
            entry_count <= '0;
        end else if (shift) begin
            time_buf.ms_hr  <= base.ls_hr;
            time_buf.ls_hr  <= base.ms_min;
            time_buf.ms_min <= base.ls_min;
            time_buf.ls_min <= digit;
            if (clear)
                entry_count <= 3'd1;
            else if (entry_count != 3'd4)
                entry_count <= entry_count + 3'd1;
        end else if (clear) begin
            time_buf    <= '0;
            entry_count <= '0;
        end else if (clear_count) begin
            entry_count <= '0;
        end
    end

    assign valid_time = (entry_count == 3'd4) && time_is_valid(time_buf);

endmodule

// File: rtl/alarm_clock_ctrl.sv
// alarm_clock_ctrl: keypad-driven control FSM for the alarm clock.
//   clk, reset        : clock, async active-high reset
//   one_second        : one-cycle pulse per second
//   key_valid/key_code: keypad strobe and code (0-9 digit, A alarm, B time)
//   new_time_*        : entry buffer nibbles (HH:MM)
//   load_new_c/_a     : one-cycle commit pulses to time counter / alarm reg
//   show_new_time     : display entry buffer (ENTRY)
//   show_alarm        : display alarm time (SHOW_ALARM)
//   entry_count       : digits entered, 0..4
//   entry_error       : one-cycle pulse on a rejected commit
module alarm_clock_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_S    = 10,
    parameter int unsigned SHOW_ALARM_S = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] new_time_ms_hr,
    output logic [3:0] new_time_ls_hr,
    output logic [3:0] new_time_ms_min,
    output logic [3:0] new_time_ls_min,
    output logic       load_new_c,
    output logic       load_new_a,
    output logic       show_new_time,
    output logic       show_alarm,
    output logic [2:0] entry_count,
    output logic       entry_error
);

    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_S - 1);
    localparam logic [3:0] SHOW_LAST    = 4'(SHOW_ALARM_S - 1);

    state_t     state;
    logic [3:0] sec_cnt;
    logic       accepted;
    logic       is_digit;
    logic       timeout_hit;
    logic       buf_clear;
    logic       buf_clear_count;
    logic       buf_shift;
    logic       valid_time;
    bcd_time_t  time_buf;

    assign accepted    = key_valid && (key_code <= KEY_TIME);
    assign is_digit    = key_code <= 4'd9;
    // An accepted key in the same cycle takes priority over the timeout
    assign timeout_hit = one_second && !accepted && (sec_cnt == TIMEOUT_LAST);

    always_comb begin
        buf_clear       = 1'b0;
        buf_clear_count = 1'b0;
        buf_shift       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accepted && is_digit) begin
                    buf_clear = 1'b1;
                    buf_shift = 1'b1;
                end
            end
            ST_ENTRY: begin
                if (accepted) begin
                    if (is_digit)
                        buf_shift = 1'b1;
                    else if (valid_time)
                        buf_clear_count = 1'b1;
                    else
                        buf_clear = 1'b1;
                end else if (timeout_hit) begin
                    buf_clear = 1'b1;
                end
            end
            default: ;
        endcase
    end

    key_entry_buffer u_buf (
        .clk         (clk),
        .reset       (reset),
        .clear       (buf_clear),
        .clear_count (buf_clear_count),
        .shift       (buf_shift),
        .digit       (key_code),
        .time_buf    (time_buf),
        .entry_count (entry_count),
        .valid_time  (valid_time)
    );

    assign new_time_ms_hr  = time_buf.ms_hr;
    assign new_time_ls_hr  = time_buf.ls_hr;
    assign new_time_ms_min = time_buf.ms_min;
    assign new_time_ls_min = time_buf.ls_min;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            sec_cnt       <= '0;
            load_new_c    <= 1'b0;
            load_new_a    <= 1'b0;
            show_new_time <= 1'b0;
            show_alarm    <= 1'b0;
            entry_error   <= 1'b0;
        end else begin
            load_new_c  <= 1'b0;
            load_new_a  <= 1'b0;
            entry_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sec_cnt <= '0;
                    if (accepted && is_digit) begin
                        state         <= ST_ENTRY;
                        show_new_time <= 1'b1;
                    end else if (accepted && key_code == KEY_ALARM) begin
                        state      <= ST_SHOW_ALARM;
                        show_alarm <= 1'b1;
                    end
                end
                ST_ENTRY: begin
                    if (accepted) begin
                        sec_cnt <= '0;
                        if (!is_digit) begin
                            state         <= ST_IDLE;
                            show_new_time <= 1'b0;
                            if (!valid_time)
                                entry_error <= 1'b1;
                            else if (key_code == KEY_TIME)
                                load_new_c <= 1'b1;
                            else
                                load_new_a <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state         <= ST_IDLE;
                        show_new_time <= 1'b0;
                        sec_cnt       <= '0;
                    end else if (one_second) begin
                        sec_cnt <= sec_cnt + 4'd1;
                    end
                end
                ST_SHOW_ALARM: begin
                    if (accepted || (one_second && sec_cnt == SHOW_LAST)) begin
                        state      <= ST_IDLE;
                        show_alarm <= 1'b0;
                        sec_cnt    <= '0;
                    end else if (one_second) begin
                        sec_cnt <= sec_cnt + 4'd1;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    sec_cnt       <= '0;
                    show_new_time <= 1'b0;
                    show_alarm    <= 1'b0;
                end
            endcase
        end
    end

endmodule
